// File: rtl/display_scanner_if.sv
// Digit data in, multiplexed anode/segment drive out for the 7-segment scanner.
// The master side supplies digits and enables; the scanner sits on the slave side.
interface display_scanner_if #(
   parameter int NUM_DIGITS = 4
);
   logic [4*NUM_DIGITS-1:0] data;
   logic [NUM_DIGITS-1:0]   digit_en;
   logic [7:0]              an;
   logic [6:0]              seg;
   logic                    frame_tick;

   modport master (output data, digit_en, input an, seg, frame_tick);
   modport slave  (input data, digit_en, output an, seg, frame_tick);
endinterface

// File: rtl/display_scanner.sv
// Time-multiplexed common-anode 7-segment scanner with per-slot blanking
// and frame-level double buffering of digit data and enables.
module display_scanner #(
   parameter int NUM_DIGITS   = 4,
   parameter int REFRESH_DIV  = 100000,
   parameter int BLANK_CYCLES = 1000
) (
   input logic             clk,
   input logic             rst_n,
   display_scanner_if.slave bus
);
   localparam int CNT_W = $clog2(REFRESH_DIV);
   localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

   logic [CNT_W-1:0]              cnt;
   logic [IDX_W-1:0]              idx;
   logic [4*NUM_DIGITS-1:0]       shadow_data;
   logic [NUM_DIGITS-1:0]         shadow_en;
   logic [NUM_DIGITS-1:0][6:0]    dig_seg;
   logic [7:0]                    an_q, an_nxt;
   logic [6:0]                    seg_q, seg_nxt;
   logic                          tick_q;
   logic                          slot_end, frame_start, blank;

   function automatic logic [6:0] decode(input logic [3:0] h);
      logic [6:0] s;
      case (h)
         4'h0: s = 7'h40;  4'h1: s = 7'h79;  4'h2: s = 7'h24;  4'h3: s = 7'h30;
         4'h4: s = 7'h19;  4'h5: s = 7'h12;  4'h6: s = 7'h02;  4'h7: s = 7'h78;
         4'h8: s = 7'h00;  4'h9: s = 7'h10;  4'hA: s = 7'h08;  4'hB: s = 7'h03;
         4'hC: s = 7'h46;  4'hD: s = 7'h21;  4'hE: s = 7'h06;  default: s = 7'h0E;
      endcase
      return s;
   endfunction

   assign slot_end    = (cnt == CNT_W'(REFRESH_DIV - 1));
   assign frame_start = (cnt == '0) && (idx == '0);
   assign blank       = (cnt < CNT_W'(BLANK_CYCLES));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt <= '0;
         idx <= '0;
      end else if (slot_end) begin
         cnt <= '0;
         idx <= (idx == IDX_W'(NUM_DIGITS - 1)) ? '0 : idx + 1'b1;
      end else begin
         cnt <= cnt + 1'b1;
      end
   end

   // Shadow copy is only refreshed at the top of a frame so a frame never mixes old/new digits.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         shadow_data <= '0;
         shadow_en   <= '0;
      end else if (frame_start) begin
         shadow_data <= bus.data;
         shadow_en   <= bus.digit_en;
      end
   end

   for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_dig
      assign dig_seg[g] = decode(shadow_data[4*g +: 4]);
   end

   // Blanking at slot start guarantees the old anode is off before the new one turns on.
   always_comb begin
      an_nxt  = 8'hFF;
      seg_nxt = 7'h7F;
      if (!blank && shadow_en[idx]) begin
         an_nxt  = ~(8'd1 << idx);
         seg_nxt = dig_seg[idx];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         an_q   <= 8'hFF;
         seg_q  <= 7'h7F;
         tick_q <= 1'b0;
      end else begin
         an_q   <= an_nxt;
         seg_q  <= seg_nxt;
         tick_q <= frame_start;
      end
   end

   assign bus.an         = an_q;
   assign bus.seg        = seg_q;
   assign bus.frame_tick = tick_q;
endmodule
